// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a scanned four-digit 8-segment display: filters scan
// transitions, decodes each digit back to nibble+dp and reassembles the 20-bit word.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES   = 1 << 20,
    parameter int DRAIN_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [3:0]  i_drains,
    input  logic [7:0]  i_leds,
    output logic [19:0] o_data,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_timeout
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CAP_THR    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic             DRAIN_INV  = (DRAIN_ACTIVE_LOW != 0);
    localparam logic             SEG_INV    = (SEG_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT} state_t;

    // NOTE: reset asserts asynchronously but releases two clocks later, so every
    // downstream flop leaves reset on a clean edge.
    logic [1:0] rst_sync_q;
    logic       rst;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) rst_sync_q <= 2'b11;
        else       rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst = rst_sync_q[1];

    logic [11:0]      sync1_q, sync2_q, prev_q;
    logic [3:0]       sel;
    logic [7:0]       seg;
    logic [11:0]      sample;
    logic             stable, onehot, capture;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [19:0]      shadow_q, shadow_d, data_q, data_d;
    logic [3:0]       mask_q, mask_d;
    logic             err_acc_q, err_acc_d, err_q, err_d;
    logic             valid_q, valid_d, tmo_q, tmo_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [4:0]       dec;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F: r = 5'h00;  7'h06: r = 5'h01;  7'h5B: r = 5'h02;  7'h4F: r = 5'h03;
            7'h66: r = 5'h04;  7'h6D: r = 5'h05;  7'h7D: r = 5'h06;  7'h07: r = 5'h07;
            7'h7F: r = 5'h08;  7'h6F: r = 5'h09;  7'h77: r = 5'h0A;  7'h7C: r = 5'h0B;
            7'h39: r = 5'h0C;  7'h5E: r = 5'h0D;  7'h79: r = 5'h0E;  7'h71: r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    assign sel    = sync2_q[11:8] ^ {4{DRAIN_INV}};
    assign seg    = sync2_q[7:0]  ^ {8{SEG_INV}};
    assign sample = {sel, seg};
    assign stable = (sample == prev_q);
    assign onehot = $onehot(sel);
    assign dec    = decode(seg[6:0]);
    assign cnt_d  = !stable ? '0 : (cnt_q == STABLE_MAX ? cnt_q : cnt_q + CNT_W'(1));

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: if (onehot) state_d = S_WAIT;
            S_WAIT: begin
                if (!onehot) begin
                    state_d = S_IDLE;
                end else if (cnt_d >= CAP_THR) begin
                    capture = 1'b1;
                    state_d = S_CAPT;
                end
            end
            S_CAPT:  if (!stable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        shadow_d  = shadow_q;
        mask_d    = mask_q;
        err_acc_d = err_acc_q;
        data_d    = data_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        tmo_d     = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    shadow_d[4*i +: 4] = dec[3:0];
                    shadow_d[16 + i]   = seg[7];
                end
            end
            mask_d    = mask_q | sel;
            err_acc_d = err_acc_q | dec[4];
            if (mask_d == 4'hF) begin
                data_d    = shadow_d;
                err_d     = err_acc_d;
                valid_d   = 1'b1;
                mask_d    = '0;
                err_acc_d = 1'b0;
            end
        end
        // A capture restarts the timeout, so completion always wins over timeout.
        if (capture || mask_q == '0) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_cnt_d = '0;
            tmo_d     = 1'b1;
            mask_d    = '0;
            err_acc_d = 1'b0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge i_CLK or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            mask_q    <= '0;
            err_acc_q <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            sync1_q   <= {i_drains, i_leds};
            sync2_q   <= sync1_q;
            prev_q    <= sample;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            mask_q    <= mask_d;
            err_acc_q <= err_acc_d;
            data_q    <= data_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_err     = err_q;
    assign o_timeout = tmo_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: table of full-frame scans plus hand-written
// glitch, blanking, timeout and mid-frame reset sequences.
module tb_seg_scan_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  drains;
    logic [7:0]  leds;
    logic [19:0] o_data;
    logic        o_valid, o_err, o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int tmo_cnt   = 0;
    int vbase, tbase;

    typedef struct {
        logic [31:0] segs;   // byte i = leds pattern for digit i
        logic [19:0] data;
        logic        err;
    } vec_t;
    vec_t vecs [4];

    seg_scan_decoder #(
        .STABLE_CYCLES   (16),
        .TIMEOUT_CYCLES  (256),
        .DRAIN_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW  (0)
    ) dut (
        .i_CLK    (clk),
        .i_RST    (rst),
        .i_drains (drains),
        .i_leds   (leds),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_err    (o_err),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid)   valid_cnt++;
        if (o_timeout) tmo_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic show(input int d, input logic [7:0] s, input int n);
        drains = ~(4'b0001 << d);
        leds   = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] dr, input int n);
        drains = dr;
        leds   = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] segs);
        for (int i = 0; i < 4; i++) show(i, segs[8*i +: 8], 64);
        hold(4'hF, 40);
    endtask

    initial begin
        vecs[0] = '{segs: 32'h06_5B_4F_66, data: 20'h01234, err: 1'b0};
        vecs[1] = '{segs: 32'h71_00_86_7F, data: 20'h2F018, err: 1'b1};
        vecs[2] = '{segs: 32'hDE_B9_7C_77, data: 20'hCDCBA, err: 1'b0};
        vecs[3] = '{segs: 32'hED_EF_F1_F9, data: 20'hF59FE, err: 1'b0};

        rst = 1'b1; drains = 4'hF; leds = 8'h00;
        repeat (4) @(negedge clk);
        check("reset o_data", o_data, 0);
        check("reset o_valid", o_valid, 0);
        check("reset o_err", o_err, 0);
        check("reset o_timeout", o_timeout, 0);
        rst = 1'b0;
        hold(4'hF, 10);

        for (int v = 0; v < 4; v++) begin
            vbase = valid_cnt;
            scan(vecs[v].segs);
            check($sformatf("vec%0d valid pulses", v), valid_cnt - vbase, 1);
            check($sformatf("vec%0d o_data", v), o_data, vecs[v].data);
            check($sformatf("vec%0d o_err", v), o_err, vecs[v].err);
        end

        // Short 0x06 glitch on digit 0 must never be captured.
        vbase = valid_cnt;
        show(0, 8'h06, 10);
        show(0, 8'h3F, 40);
        show(1, 8'h06, 64);
        show(2, 8'h5B, 64);
        show(3, 8'h4F, 64);
        hold(4'hF, 40);
        check("glitch valid pulses", valid_cnt - vbase, 1);
        check("glitch digit0 nibble", o_data[3:0], 4'h0);
        check("glitch o_data", o_data, 20'h03210);

        // Blanking and overlapping drains between digits.
        vbase = valid_cnt; tbase = tmo_cnt;
        show(0, 8'h07, 64);
        hold(4'hF, 100);
        show(1, 8'h6D, 64);
        hold(4'b1100, 100);
        show(2, 8'h7D, 64);
        hold(4'h0, 100);
        show(3, 8'h66, 64);
        hold(4'hF, 40);
        check("blank valid pulses", valid_cnt - vbase, 1);
        check("blank o_data", o_data, 20'h04657);
        check("blank no timeout", tmo_cnt - tbase, 0);

        // Partial frame abandoned, then a clean frame.
        vbase = valid_cnt; tbase = tmo_cnt;
        show(0, 8'h3F, 64);
        show(1, 8'h06, 64);
        hold(4'hF, 300);
        check("timeout pulses", tmo_cnt - tbase, 1);
        check("timeout no valid", valid_cnt - vbase, 0);
        check("timeout o_data kept", o_data, 20'h04657);
        scan(vecs[0].segs);
        check("post-timeout valid pulses", valid_cnt - vbase, 1);
        check("post-timeout o_data", o_data, 20'h01234);
        check("post-timeout single timeout", tmo_cnt - tbase, 1);

        // Reset after three captures must drop the partial frame.
        show(0, 8'h5B, 64);
        show(1, 8'h4F, 64);
        show(2, 8'h66, 64);
        drains = 4'hF; leds = 8'h00;
        rst = 1'b1;
        #1;
        check("midreset o_data", o_data, 0);
        check("midreset o_valid", o_valid, 0);
        check("midreset o_err", o_err, 0);
        check("midreset o_timeout", o_timeout, 0);
        @(negedge clk);
        hold(4'hF, 3);
        rst = 1'b0;
        hold(4'hF, 10);
        vbase = valid_cnt; tbase = tmo_cnt;
        show(3, 8'h7F, 64);
        hold(4'hF, 300);
        check("midreset no carry-over valid", valid_cnt - vbase, 0);
        check("midreset partial timeout", tmo_cnt - tbase, 1);
        scan(32'h7F_3F_3F_3F);
        check("midreset full scan valid", valid_cnt - vbase, 1);
        check("midreset full scan o_data", o_data, 20'h08000);
        check("midreset full scan o_err", o_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
